key_pio_edge: RTL and testbench

KEY_PIO_EDGE -- requirements
Module: key_pio_edge

---
 rtl/key_pio_edge.sv | 164 ++++++++++++++++
 tb/tb_key_pio_edge.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/key_pio_edge.sv
// key_pio_edge
// Avalon-MM key/button PIO with optional per-channel debounce, edge capture
// and a level interrupt.
//
// Parameters
//   WIDTH           number of key channels (1..32)
//   DEBOUNCE_CYCLES stable cycles needed before a channel change is accepted
//   EDGE_TYPE       0 = rising, 1 = falling, 2 = any edge
//
// Build option
//   KEY_PIO_DEBOUNCE_EN  defined   -> per-channel debounce counters present
//                        undefined -> debounced state is the synchronized
//                                     input (DEBOUNCE_CYCLES unused)
//
// Ports
//   clk        single clock, rising edge
//   reset      synchronous, active-high
//   address    word address: 0 state (RO), 1 reserved, 2 irq_mask (RW),
//              3 edge_capture (write-1-to-clear)
//   chipselect slave select
//   write      write strobe, qualified by chipselect
//   writedata  write data; bits above WIDTH ignored
//   in_port    asynchronous key inputs, idle high
//   readdata   registered read data, 1-cycle latency, no read strobe
//   irq        |(edge_capture & irq_mask)
//
// Bus handshake: no wait states. A write is accepted on any rising edge where
// chipselect && write; readdata reflects the address presented on the
// previous edge.
module key_pio_edge #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] EDGE_RISE = 2'd0;
  localparam logic [1:0] EDGE_FALL = 2'd1;
  localparam logic [1:0] EDGE_ANY  = 2'd2;
  localparam logic [1:0] EDGE_SEL  = 2'(EDGE_TYPE);

  // Two-flop synchronizer; reset to idle-high so release creates no edge.
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  logic [WIDTH-1:0] deb;

`ifdef KEY_PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  // The count reaches DEBOUNCE_CYCLES-1 after that many differing cycles;
  // the next differing cycle is the DEBOUNCE_CYCLES-th and flips the state.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  logic [CW-1:0] cnt [WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      deb <= '1;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else if (cnt[i] != CNT_MAX) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  always_comb deb = sync2;
`endif

  // Previous debounced state; edges are seen in the cycle deb differs from it.
  logic [WIDTH-1:0] deb_d;

  always_ff @(posedge clk) begin
    if (reset) deb_d <= '1;
    else       deb_d <= deb;
  end

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_hit;

  always_comb begin
    rise = deb & ~deb_d;
    fall = ~deb & deb_d;
    edge_hit = '0;
    case (EDGE_SEL)
      EDGE_RISE: edge_hit = rise;
      EDGE_FALL: edge_hit = fall;
      EDGE_ANY:  edge_hit = rise | fall;
      default:   edge_hit = fall;
    endcase
  end

  // Register file
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic             wr_en;
  logic [WIDTH-1:0] wr_val;
  logic [WIDTH-1:0] clr;

  always_comb begin
    wr_en  = chipselect && write;
    wr_val = writedata[WIDTH-1:0];
    clr    = (wr_en && address == 2'd3) ? wr_val : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_en && address == 2'd2) irq_mask <= wr_val;
      // OR-ing the new edge after the clear gives set priority.
      edge_capture <= (edge_capture & ~clr) | edge_hit;
    end
  end

  logic [31:0] rd_next;

  always_comb begin
    rd_next = '0;
    case (address)
      2'd0:    rd_next[WIDTH-1:0] = deb;
      2'd2:    rd_next[WIDTH-1:0] = irq_mask;
      2'd3:    rd_next[WIDTH-1:0] = edge_capture;
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_next;
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_key_pio_edge.sv
module tb_key_pio_edge;

  localparam int W = 4;
  localparam int N = 4;
`ifdef KEY_PIO_DEBOUNCE_EN
  localparam int LAT = 2 + N;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [W-1:0] in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  key_pio_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(N), .EDGE_TYPE(1)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  // clock
  always #5 clk = ~clk;

  // Advance one clock; inputs and samples sit 1 time unit after the edge.
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write      = 1'b1;
    cyc();
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input string tag, input logic [31:0] exp);
    address = a;
    cyc();
    check(tag, readdata, exp);
  endtask

  initial begin
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write = 1'b0;
    writedata = '0; in_port = 4'hF;
    cyc(3);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;

    // idle read
    bus_read(2'd0, "idle_state", 32'h0000000F);
    check("idle_irq", {31'b0, irq}, 32'h0);

    // falling edge on bit 2
    address = 2'd0;
    in_port = 4'hB;
    cyc(LAT);
    check("fall2_not_yet", readdata, 32'hF);
    cyc();
    check("fall2_state", readdata, 32'hB);
    bus_read(2'd3, "fall2_capture", 32'h4);
    check("fall2_irq_masked", {31'b0, irq}, 32'h0);
    bus_write(2'd2, 32'h4);
    check("fall2_irq", {31'b0, irq}, 32'h1);
    bus_read(2'd2, "mask_read", 32'h4);

    // rising edge is not captured; then clear
    in_port = 4'hF;
    cyc(LAT + 3);
    bus_read(2'd3, "rise_no_capture", 32'h4);
    bus_write(2'd3, 32'h4);
    check("clear_irq", {31'b0, irq}, 32'h0);
    bus_read(2'd3, "clear_capture", 32'h0);

`ifdef KEY_PIO_DEBOUNCE_EN
    // 3-cycle glitch on bit 0 is rejected
    address = 2'd0;
    in_port = 4'hE;
    cyc(3);
    in_port = 4'hF;
    cyc(10);
    check("glitch_state", readdata, 32'hF);
    bus_read(2'd3, "glitch_capture", 32'h0);
    check("glitch_irq", {31'b0, irq}, 32'h0);
`else
    // 1-cycle pulse on bit 1 passes straight through
    address = 2'd0;
    in_port = 4'hD;
    cyc();
    in_port = 4'hF;
    cyc(2);
    check("pulse_state", readdata, 32'hD);
    bus_read(2'd3, "pulse_capture", 32'h2);
    bus_write(2'd3, 32'h2);
    bus_read(2'd3, "pulse_cleared", 32'h0);
`endif

    // capture = 4 again
    in_port = 4'hB;
    cyc(LAT + 2);
    bus_read(2'd3, "cap4", 32'h4);
    in_port = 4'hF;
    cyc(LAT + 3);
    // new falling edge on bit 2 coinciding with a clear of bit 2: set wins
    in_port = 4'hB;
    cyc(LAT);
    bus_write(2'd3, 32'h4);
    bus_read(2'd3, "set_priority", 32'h4);

    // capture = 6, mask = 2, clear bit 1
    in_port = 4'h9;
    cyc(LAT + 2);
    bus_read(2'd3, "cap6", 32'h6);
    bus_write(2'd2, 32'hFFFF_FFF2);
    bus_read(2'd2, "mask_upper_ignored", 32'h2);
    check("irq_before_clear", {31'b0, irq}, 32'h1);
    bus_write(2'd3, 32'h2);
    check("irq_after_clear", {31'b0, irq}, 32'h0);
    bus_read(2'd3, "cap_after_clear", 32'h4);

    // reserved address
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, "reserved_read", 32'h0);
    bus_read(2'd0, "state_9", 32'h9);

    // reset clears registers
    reset = 1'b1;
    cyc();
    check("reset2_readdata", readdata, 32'h0);
    reset = 1'b0;
    bus_read(2'd3, "reset2_capture", 32'h0);
    bus_read(2'd2, "reset2_mask", 32'h0);
    check("reset2_irq", {31'b0, irq}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
